// File: rtl/jam_perm_gen_pkg.sv
// Shared types and constants for the JAM permutation source and the
// downstream cost-accumulate / min-tracking stage.
package jam_perm_gen_pkg;

  // Default problem size: workers = jobs.
  localparam int N_JOBS   = 8;
  // Bits per permutation element.
  localparam int JAM_EW   = $clog2(N_JOBS);
  // Ordinal counter width; N_JOBS! must fit.
  localparam int JAM_IDXW = 16;

  // perm[k] is the job assigned to worker k.
  typedef logic [N_JOBS-1:0][JAM_EW-1:0] perm_t;

  // Generator FSM states.
  typedef enum logic [2:0] {
    IDLE,
    OUT,
    PIVOT,
    SWAP,
    REV
  } perm_state_e;

endpackage

// File: rtl/jam_perm_gen_if.sv
// Permutation stream bundle: control inputs, valid/ready handshake and
// the presented permutation with its ordinal.
interface jam_perm_gen_if
  import jam_perm_gen_pkg::*;
#(
  parameter int N    = N_JOBS,
  parameter int EW   = $clog2(N),
  parameter int IDXW = JAM_IDXW
);

  logic              start;
  logic              perm_ready;
  logic              perm_valid;
  logic [N*EW-1:0]   perm;
  logic [IDXW-1:0]   perm_idx;
  logic              perm_last;
  logic              busy;
  logic              done;

  // Generator side.
  modport master (
    input  start, perm_ready,
    output perm_valid, perm, perm_idx, perm_last, busy, done
  );

  // Consumer / controller side.
  modport slave (
    output start, perm_ready,
    input  perm_valid, perm, perm_idx, perm_last, busy, done
  );

endinterface

// File: rtl/jam_perm_gen_pivot.sv
// Combinational pivot finder for next-permutation:
//   pivot_i = highest k with p[k] < p[k+1]
//   succ_j  = highest k > pivot_i with p[k] > p[pivot_i]
// pivot_found is low when the permutation is strictly descending.
module jam_perm_gen_pivot
  import jam_perm_gen_pkg::*;
#(
  parameter int N  = N_JOBS,
  parameter int EW = $clog2(N)
) (
  input  logic [N-1:0][EW-1:0] i_perm,
  output logic                 o_pivot_found,
  output logic [EW-1:0]        o_pivot_i,
  output logic [EW-1:0]        o_succ_j
);

  logic [N-2:0] w_asc;
  logic [N-1:0] w_gt;
  logic [EW-1:0] w_pivot_val;

  // Ascending-pair flags, one per adjacent pair.
  generate
    for (genvar gi = 0; gi < N - 1; gi++) begin : g_asc
      assign w_asc[gi] = (i_perm[gi] < i_perm[gi+1]);
    end
  endgenerate

  assign o_pivot_found = |w_asc;
  assign w_pivot_val   = i_perm[o_pivot_i];

  // Successor candidates: right of the pivot and larger than it.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_gt
      assign w_gt[gi] = (EW'(gi) > o_pivot_i) && (i_perm[gi] > w_pivot_val);
    end
  endgenerate

  // Priority encoder on ascending pairs, highest index wins.
  always_comb begin
    o_pivot_i = '0;
    for (int k = 0; k < N - 1; k++) begin
      if (w_asc[k]) o_pivot_i = EW'(k);
    end
  end

  // Priority encoder on successor candidates, highest index wins.
  always_comb begin
    o_succ_j = '0;
    for (int k = 0; k < N; k++) begin
      if (w_gt[k]) o_succ_j = EW'(k);
    end
  end

endmodule

// File: rtl/jam_perm_gen.sv
// JAM permutation source: walks all N! worker->job assignments in
// lexicographic order, presenting one per valid/ready handshake.
// Each step is PIVOT (find i/j), SWAP (p[i]<->p[j]) and then one REV
// cycle per pair of the suffix that must be reversed.
module jam_perm_gen
  import jam_perm_gen_pkg::*;
#(
  parameter int N    = N_JOBS,
  parameter int EW   = $clog2(N),
  parameter int IDXW = JAM_IDXW
) (
  input  logic             CLK,
  input  logic             RST,
  jam_perm_gen_if.master   bus
);

  perm_state_e               r_state;
  logic [N-1:0][EW-1:0]      r_perm;
  logic [N-1:0][EW-1:0]      w_identity;
  logic [IDXW-1:0]           r_perm_idx;
  logic                      r_perm_valid;
  logic                      r_busy;
  logic                      r_done;
  logic [EW-1:0]             r_i;
  logic [EW-1:0]             r_j;
  logic [EW-1:0]             r_l;
  logic [EW-1:0]             r_r;
  logic [EW-1:0]             w_l_inc;
  logic [EW-1:0]             w_r_dec;
  logic                      w_pivot_found;
  logic [EW-1:0]             w_pivot_i;
  logic [EW-1:0]             w_succ_j;

  // Identity permutation: element k = k.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ident
      assign w_identity[gi] = EW'(gi);
    end
  endgenerate

  jam_perm_gen_pivot #(
    .N  (N),
    .EW (EW)
  ) u_pivot (
    .i_perm        (r_perm),
    .o_pivot_found (w_pivot_found),
    .o_pivot_i     (w_pivot_i),
    .o_succ_j      (w_succ_j)
  );

  // The reverse pointers never leave 0..N-1 while they are live.
  assign w_l_inc = r_l + EW'(1);
  assign w_r_dec = r_r - EW'(1);

  // Main FSM: enumeration control, permutation register and ordinal counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_perm       <= w_identity;
      r_perm_idx   <= '0;
      r_perm_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_i          <= '0;
      r_j          <= '0;
      r_l          <= '0;
      r_r          <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_perm       <= w_identity;
            r_perm_idx   <= '0;
            r_perm_valid <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= OUT;
          end
        end
        OUT: begin
          if (bus.perm_ready) begin
            r_perm_valid <= 1'b0;
            if (!w_pivot_found) begin
              // Strictly descending: that was the final permutation.
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= PIVOT;
            end
          end
        end
        PIVOT: begin
          r_i     <= w_pivot_i;
          r_j     <= w_succ_j;
          r_l     <= w_pivot_i + EW'(1);
          r_r     <= EW'(N - 1);
          r_state <= SWAP;
        end
        SWAP: begin
          r_perm[r_i] <= r_perm[r_j];
          r_perm[r_j] <= r_perm[r_i];
          if (r_l >= r_r) begin
            r_perm_idx   <= r_perm_idx + IDXW'(1);
            r_perm_valid <= 1'b1;
            r_state      <= OUT;
          end else begin
            r_state <= REV;
          end
        end
        REV: begin
          r_perm[r_l] <= r_perm[r_r];
          r_perm[r_r] <= r_perm[r_l];
          r_l         <= w_l_inc;
          r_r         <= w_r_dec;
          if (w_l_inc >= w_r_dec) begin
            r_perm_idx   <= r_perm_idx + IDXW'(1);
            r_perm_valid <= 1'b1;
            r_state      <= OUT;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.perm_valid = r_perm_valid;
  assign bus.perm       = r_perm;
  assign bus.perm_idx   = r_perm_idx;
  assign bus.perm_last  = r_perm_valid & ~w_pivot_found;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_jam_perm_gen.sv
// Bench for jam_perm_gen: an N=8 instance (partial runs, backpressure,
// mid-run reset) and an N=3 instance (full enumeration, last/done).
// Expected permutations come from a reference next-permutation model and
// travel through a per-instance scoreboard queue.
module tb_jam_perm_gen;
  import jam_perm_gen_pkg::*;

  localparam int NA = 8;
  localparam int EA = 3;
  localparam int NB = 3;
  localparam int EB = 2;
  localparam int IW = 16;

  typedef struct {
    logic [23:0] perm;
    logic [15:0] idx;
    logic        last;
    int          gap;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  jam_perm_gen_if #(.N(NA), .EW(EA), .IDXW(IW)) bus_a ();
  jam_perm_gen_if #(.N(NB), .EW(EB), .IDXW(IW)) bus_b ();

  jam_perm_gen #(.N(NA), .EW(EA), .IDXW(IW)) dut_a (.CLK(CLK), .RST(RST), .bus(bus_a));
  jam_perm_gen #(.N(NB), .EW(EB), .IDXW(IW)) dut_b (.CLK(CLK), .RST(RST), .bus(bus_b));

  logic        start_v [2];
  logic        ready_v [2];
  logic        o_valid [2];
  logic        o_last  [2];
  logic        o_busy  [2];
  logic        o_done  [2];
  logic [23:0] o_perm  [2];
  logic [15:0] o_idx   [2];

  assign bus_a.start      = start_v[0];
  assign bus_a.perm_ready = ready_v[0];
  assign bus_b.start      = start_v[1];
  assign bus_b.perm_ready = ready_v[1];

  assign o_valid[0] = bus_a.perm_valid;
  assign o_valid[1] = bus_b.perm_valid;
  assign o_last[0]  = bus_a.perm_last;
  assign o_last[1]  = bus_b.perm_last;
  assign o_busy[0]  = bus_a.busy;
  assign o_busy[1]  = bus_b.busy;
  assign o_done[0]  = bus_a.done;
  assign o_done[1]  = bus_b.done;
  assign o_perm[0]  = 24'(bus_a.perm);
  assign o_perm[1]  = 24'(bus_b.perm);
  assign o_idx[0]   = bus_a.perm_idx;
  assign o_idx[1]   = bus_b.perm_idx;

  int errors = 0;
  int checks = 0;

  // Reference model state per instance.
  int          mp   [2][8];
  int          nn   [2] = '{NA, NB};
  int          ew   [2] = '{EA, EB};
  logic [15:0] midx [2];
  exp_t        sb0[$];
  exp_t        sb1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic void m_reset(input int d);
    for (int k = 0; k < 8; k++) mp[d][k] = k;
    midx[d] = '0;
  endfunction

  function automatic int m_pivot(input int d);
    int r = -1;
    for (int k = 0; k < nn[d] - 1; k++) if (mp[d][k] < mp[d][k+1]) r = k;
    return r;
  endfunction

  function automatic void m_next(input int d);
    int i, j, t, l, r;
    i = m_pivot(d);
    j = i + 1;
    for (int k = i + 1; k < nn[d]; k++) if (mp[d][k] > mp[d][i]) j = k;
    t = mp[d][i]; mp[d][i] = mp[d][j]; mp[d][j] = t;
    l = i + 1;
    r = nn[d] - 1;
    while (l < r) begin
      t = mp[d][l]; mp[d][l] = mp[d][r]; mp[d][r] = t;
      l++;
      r--;
    end
  endfunction

  function automatic logic [23:0] m_pack(input int d);
    logic [23:0] v = '0;
    for (int k = 0; k < nn[d]; k++) v = v | (24'(mp[d][k]) << (ew[d] * k));
    return v;
  endfunction

  function automatic void sb_push(input int d, input exp_t e);
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endfunction

  function automatic int sb_size(input int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic exp_t sb_pop(input int d);
    exp_t e;
    if (d == 0) e = sb0.pop_front();
    else        e = sb1.pop_front();
    return e;
  endfunction

  // Pulse start for one cycle; the identity must be presented right after.
  task automatic start_run(input int d, input bit bp);
    exp_t e;
    ready_v[d] = !bp;
    m_reset(d);
    e.perm = m_pack(d);
    e.idx  = '0;
    e.last = 1'b0;
    e.gap  = 0;
    sb_push(d, e);
    start_v[d] = 1'b1;
    @(negedge CLK);
    start_v[d] = 1'b0;
  endtask

  // Wait for the next presentation, compare it with the scoreboard head,
  // optionally stall, then accept it and queue the model's successor.
  task automatic take(input int d, input bit bp);
    exp_t e;
    exp_t nx;
    int   cnt;
    int   pi;
    chk("sb_pending", 32'(sb_size(d) > 0), 32'd1);
    e   = sb_pop(d);
    cnt = 0;
    while (o_valid[d] !== 1'b1 && cnt < 40) begin
      @(negedge CLK);
      cnt++;
    end
    chk("valid", 32'(o_valid[d]), 32'd1);
    chk("latency", 32'(cnt), 32'(e.gap));
    chk("perm", 32'(o_perm[d]), 32'(e.perm));
    chk("perm_idx", 32'(o_idx[d]), 32'(e.idx));
    chk("perm_last", 32'(o_last[d]), 32'(e.last));
    chk("busy_out", 32'(o_busy[d]), 32'd1);
    if (bp) begin
      while ($urandom_range(0, 99) >= 30) begin
        ready_v[d] = 1'b0;
        @(negedge CLK);
        chk("hold_valid", 32'(o_valid[d]), 32'd1);
        chk("hold_perm", 32'(o_perm[d]), 32'(e.perm));
        chk("hold_idx", 32'(o_idx[d]), 32'(e.idx));
      end
    end
    ready_v[d] = 1'b1;
    @(negedge CLK);
    if (bp) ready_v[d] = 1'b0;
    chk("valid_drop", 32'(o_valid[d]), 32'd0);
    chk("done", 32'(o_done[d]), 32'(e.last));
    chk("busy_after", 32'(o_busy[d]), 32'(!e.last));
    if (e.last) begin
      @(negedge CLK);
      chk("done_pulse", 32'(o_done[d]), 32'd0);
      chk("busy_idle", 32'(o_busy[d]), 32'd0);
    end else begin
      pi = m_pivot(d);
      m_next(d);
      midx[d] = midx[d] + 16'd1;
      nx.perm = m_pack(d);
      nx.idx  = midx[d];
      nx.last = (m_pivot(d) < 0);
      nx.gap  = 2 + (nn[d] - 1 - pi) / 2;
      sb_push(d, nx);
    end
  endtask

  task automatic idle_check(input string tag, input int d, input logic [23:0] p, input logic [15:0] idx);
    chk({tag, "_valid"}, 32'(o_valid[d]), 32'd0);
    chk({tag, "_last"}, 32'(o_last[d]), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy[d]), 32'd0);
    chk({tag, "_done"}, 32'(o_done[d]), 32'd0);
    chk({tag, "_idx"}, 32'(idx), 32'(o_idx[d]));
    chk({tag, "_perm"}, 32'(o_perm[d]), 32'(p));
  endtask

  initial begin
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    ready_v[0] = 1'b0; ready_v[1] = 1'b0;
    m_reset(0);
    m_reset(1);

    // Reset held three cycles, then idle with no start.
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    idle_check("rst_a", 0, m_pack(0), 16'd0);
    idle_check("rst_b", 1, m_pack(1), 16'd0);

    // N=3 full run, ready held high, start pulsed mid-run (ignored).
    start_run(1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) start_v[1] = 1'b1;
      if (k == 4) start_v[1] = 1'b0;
      take(1, 1'b0);
    end
    repeat (3) @(negedge CLK);
    idle_check("hold_b", 1, m_pack(1), 16'd5);

    // N=3 full run again under random backpressure.
    start_run(1, 1'b1);
    for (int k = 0; k < 6; k++) take(1, 1'b1);
    repeat (2) @(negedge CLK);
    idle_check("hold_b2", 1, m_pack(1), 16'd5);

    // N=8: run past ordinal 100, then reset while a reversal is in progress.
    start_run(0, 1'b0);
    take(0, 1'b0);
    while (!(midx[0] >= 16'd101 && sb0.size() > 0 && sb0[0].gap > 2) && midx[0] < 16'd400)
      take(0, 1'b0);
    chk("rev_reached", 32'(sb0[0].gap > 2), 32'd1);
    repeat (2) @(negedge CLK);
    chk("rev_busy", 32'(o_busy[0]), 32'd1);
    chk("rev_valid", 32'(o_valid[0]), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    m_reset(0);
    idle_check("abort_a", 0, m_pack(0), 16'd0);
    RST = 1'b0;
    sb0.delete();
    @(negedge CLK);
    idle_check("abort_a2", 0, m_pack(0), 16'd0);

    // N=8 restart from identity, ready held high, past the i=1 step.
    start_run(0, 1'b0);
    for (int k = 0; k < 1000; k++) take(0, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    sb0.delete();
    @(negedge CLK);

    // N=8 under random backpressure.
    start_run(0, 1'b1);
    for (int k = 0; k < 300; k++) take(0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
